memory_access_unit: RTL and testbench



---
 rtl/memory_access_unit_pkg.sv | 37 +++
 rtl/memory_access_unit_load_aligner.sv | 26 ++
 rtl/memory_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit.
package memory_access_unit_pkg;

  localparam int MAU_ADDR_WIDTH = 32;

  // RV32I funct3 size/sign encodings for loads and stores
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT    = 2'd1;
  localparam logic [1:0] ST_WAIT_RVALID = 2'd2;

  typedef enum logic [1:0] {
    FC_NONE           = 2'b00,
    FC_LOAD_MISALIGN  = 2'b01,
    FC_STORE_MISALIGN = 2'b10,
    FC_BUS_TIMEOUT    = 2'b11
  } fault_cause_e;

  // funct3 values the unit will put on the bus; anything else is rejected
  function automatic logic size_supported(input logic [2:0] f3);
    return f3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/memory_access_unit_load_aligner.sv
// Load data extraction: shift the addressed lane down and extend per funct3.
module load_aligner
  import memory_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Byte-lane shift followed by sign or zero extension
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      MEM_B:   data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  data = {24'd0, shifted[7:0]};
      MEM_HU:  data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access stage engine: one load/store at a time over a req/gnt/rvalid
// bus, with registered completion toward write-back.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int MAX_WAIT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam int CW = $clog2(MAX_WAIT_CYCLES + 1);
  // Last waiting cycle that may still see gnt/rvalid before timing out
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;

  logic          cap_store;
  logic [2:0]    cap_f3;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [4:0]    cap_rd;

  logic          accept;
  logic          unsupported;
  logic          misaligned;
  logic          wait_expired;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   load_data;

  assign accept       = (state == ST_IDLE) && req_valid && !flush;
  assign unsupported  = !size_supported(req_funct3);
  assign misaligned   = addr_misaligned(req_funct3, req_addr[1:0]);
  assign wait_expired = (wait_cnt == LAST_WAIT);
  assign stall        = (state != ST_IDLE);

  // Store-side lane selection and data replication from the captured request
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = cap_wdata;
    case (cap_f3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << cap_addr[1:0];
        lane_wdata = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {cap_addr[1], 1'b0};
        lane_wdata = {2{cap_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus outputs are held from the captured request for the whole WAIT_GNT phase
  assign dmem_req   = (state == ST_WAIT_GNT);
  assign dmem_we    = dmem_req && cap_store;
  assign dmem_be    = dmem_req ? lane_be : 4'b0000;
  assign dmem_addr  = dmem_req ? {cap_addr[31:2], 2'b00} : 32'd0;
  assign dmem_wdata = dmem_we ? lane_wdata : 32'd0;

  load_aligner u_load_aligner (
    .rdata  (dmem_rdata),
    .offset (cap_addr[1:0]),
    .funct3 (cap_f3),
    .data   (load_data)
  );

  // Request capture, state sequencing and bus wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cap_store <= 1'b0;
      cap_f3    <= 3'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_rd    <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_store <= req_is_store;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_rd    <= req_rd;
            wait_cnt  <= '0;
            if (!unsupported && !misaligned) state <= ST_WAIT_GNT;
          end
        end
        ST_WAIT_GNT: begin
          if (dmem_gnt) begin
            wait_cnt <= '0;
            state    <= cap_store ? ST_IDLE : ST_WAIT_RVALID;
          end else if (wait_expired) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT_RVALID: begin
          if (dmem_rvalid || wait_expired) state <= ST_IDLE;
          else                             wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered one-cycle completion toward write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_addr  <= 32'd0;
    end else begin
      done        <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_addr  <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (accept && unsupported) begin
            done <= 1'b1;
          end else if (accept && misaligned) begin
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= req_is_store ? FC_STORE_MISALIGN : FC_LOAD_MISALIGN;
            fault_addr  <= req_addr;
          end
        end
        ST_WAIT_GNT: begin
          if (dmem_gnt) begin
            done <= cap_store;
          end else if (wait_expired) begin
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= FC_BUS_TIMEOUT;
            fault_addr  <= cap_addr;
          end
        end
        ST_WAIT_RVALID: begin
          if (dmem_rvalid) begin
            done    <= 1'b1;
            wb_we   <= 1'b1;
            wb_rd   <= cap_rd;
            wb_data <= load_data;
          end else if (wait_expired) begin
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= FC_BUS_TIMEOUT;
            fault_addr  <= cap_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench: transaction-level model predicts each completion and
// bus request shape; a negedge compare process checks every cycle.
module tb_memory_access_unit;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        done, wb_we, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;
  logic [1:0]  fault_cause;

  memory_access_unit #(.MAX_WAIT_CYCLES(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          flt;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  exp_t expq[$];

  // Observations recorded for the literal spot checks
  int          acc_cyc;
  int          seen_done_cyc;
  logic        seen_we;
  logic [4:0]  seen_rd;
  logic [31:0] seen_data;
  logic        seen_flt;
  logic [1:0]  seen_cause;
  logic [31:0] seen_faddr;
  logic [3:0]  seen_be;
  logic [31:0] seen_baddr;
  logic [31:0] seen_bwdata;

  logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] bad_codes[3] = '{3'd3, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural load result: pick bytes from the word, then extend
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    int b[4];
    int o;
    int v;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = int'((rdata >> (8 * i)) & 32'hFF);
    case (f3)
      3'd0: v = (b[o] >= 128) ? b[o] - 256 : b[o];
      3'd1: begin v = b[o] + 256 * b[o + 1]; if (v >= 32768) v = v - 65536; end
      3'd4: v = b[o];
      3'd5: v = b[o] + 256 * b[o + 1];
      default: return rdata;
    endcase
    return 32'(v);
  endfunction

  // Compare DUT completion outputs against the model every cycle
  always @(negedge clk) begin : compare
    exp_t e;
    if (!rst) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("done", done, 1);
        chk("wb_we", wb_we, e.we);
        chk("fault", fault, e.flt);
        if (e.we) begin
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
        if (e.flt) begin
          chk("fault_cause", fault_cause, e.cause);
          chk("fault_addr", fault_addr, e.addr);
        end
        seen_done_cyc <= cyc;
        seen_we       <= wb_we;
        seen_rd       <= wb_rd;
        seen_data     <= wb_data;
        seen_flt      <= fault;
        seen_cause    <= fault_cause;
        seen_faddr    <= fault_addr;
      end else begin
        chk("done_quiet", done, 0);
        chk("wb_we_quiet", wb_we, 0);
        chk("fault_quiet", fault, 0);
      end
    end
  end

  // Drive one request and play the bus side: gnt after gk waiting cycles,
  // rvalid after rj cycles in the read phase (>= MAXW means never)
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int gk,
                       input int rj, input logic [31:0] rdv, input bit fl);
    exp_t        e;
    int          size;
    int          o;
    logic [3:0]  xbe;
    logic [31:0] xwd;
    e = '{cyc: 0, we: 0, rd: 0, data: 0, flt: 0, cause: 0, addr: 0};
    acc_cyc      = cyc;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    flush        = fl;
    chk("stall_accept", stall, 0);
    if (fl) begin
      step();
      req_valid = 1'b0;
      flush     = 1'b0;
      chk("stall_after_flush", stall, 0);
      return;
    end
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      e.cyc = cyc + 1;
      expq.push_back(e);
      step();
      req_valid = 1'b0;
      chk("req_reject", dmem_req, 0);
      return;
    end
    size = 1 << f3[1:0];
    if ((addr % size) != 0) begin
      e.cyc   = cyc + 1;
      e.flt   = 1;
      e.cause = st ? 2'b10 : 2'b01;
      e.addr  = addr;
      expq.push_back(e);
      step();
      req_valid = 1'b0;
      chk("req_misalign", dmem_req, 0);
      return;
    end
    o = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      xbe[i]         = (i >= o) && (i < o + size);
      xwd[8 * i +: 8] = wdata[8 * (i % size) +: 8];
    end
    step();
    req_valid = 1'b0;
    for (int k = 0; k < MAXW; k++) begin
      chk("stall_gnt", stall, 1);
      chk("dmem_req", dmem_req, 1);
      chk("dmem_we", dmem_we, st);
      chk("dmem_be", dmem_be, xbe);
      chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      if (st) chk("dmem_wdata", dmem_wdata, xwd);
      if (k == gk) begin
        dmem_gnt    = 1'b1;
        seen_be     = dmem_be;
        seen_baddr  = dmem_addr;
        seen_bwdata = dmem_wdata;
        if (st) begin
          e.cyc = cyc + 1;
          expq.push_back(e);
          step();
          dmem_gnt = 1'b0;
          chk("stall_store_done", stall, 0);
          return;
        end
        step();
        dmem_gnt = 1'b0;
        for (int j = 0; j < MAXW; j++) begin
          chk("stall_rvalid", stall, 1);
          chk("req_in_read", dmem_req, 0);
          if (j == rj) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdv;
            e.cyc  = cyc + 1;
            e.we   = 1;
            e.rd   = rd;
            e.data = model_load(rdv, addr[1:0], f3);
            expq.push_back(e);
            step();
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            chk("stall_load_done", stall, 0);
            return;
          end
          dmem_rdata = $urandom;
          if (j == MAXW - 1) begin
            e.cyc   = cyc + 1;
            e.flt   = 1;
            e.cause = 2'b11;
            e.addr  = addr;
            expq.push_back(e);
            step();
            chk("stall_rto", stall, 0);
            return;
          end
          step();
        end
      end
      // Stray read data while waiting for grant must be ignored
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      if (k == MAXW - 1) begin
        e.cyc   = cyc + 1;
        e.flt   = 1;
        e.cause = 2'b11;
        e.addr  = addr;
        expq.push_back(e);
        step();
        dmem_rvalid = 1'b0;
        chk("req_drop_gto", dmem_req, 0);
        chk("stall_gto", stall, 0);
        return;
      end
      step();
      dmem_rvalid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          size;

    repeat (3) step();
    chk("rst_stall", stall, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_cause", fault_cause, 0);
    chk("rst_fault_addr", fault_addr, 0);
    rst = 1'b0;
    step();

    // SW 0x100, immediate grant
    do_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0);
    step();
    chk("sw_be", seen_be, 4'b1111);
    chk("sw_addr", seen_baddr, 32'h100);
    chk("sw_wdata", seen_bwdata, 32'hDEADBEEF);
    chk("sw_done_lat", 32'(seen_done_cyc - acc_cyc), 2);
    chk("sw_wb_we", seen_we, 0);

    // LB / LBU at 0x103
    do_op(0, 3'b000, 32'h103, 0, 5'd7, 0, 0, 32'h80FF0000, 0);
    step();
    chk("lb_data", seen_data, 32'hFFFFFF80);
    chk("lb_we", seen_we, 1);
    chk("lb_rd", seen_rd, 5'd7);
    chk("lb_done_lat", 32'(seen_done_cyc - acc_cyc), 3);
    do_op(0, 3'b100, 32'h103, 0, 5'd9, 0, 0, 32'h80FF0000, 0);
    step();
    chk("lbu_data", seen_data, 32'h00000080);

    // SH 0x102 lane replication
    do_op(1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 0, 0, 0, 0);
    step();
    chk("sh_be", seen_be, 4'b1100);
    chk("sh_addr", seen_baddr, 32'h100);
    chk("sh_wdata", seen_bwdata, 32'hABCDABCD);

    // Misaligned LW
    do_op(0, 3'b010, 32'h102, 0, 5'd3, 0, 0, 0, 0);
    step();
    chk("lw_mis_fault", seen_flt, 1);
    chk("lw_mis_cause", seen_cause, 2'b01);
    chk("lw_mis_addr", seen_faddr, 32'h102);
    chk("lw_mis_lat", 32'(seen_done_cyc - acc_cyc), 1);

    // LW with slow grant and slow read data
    do_op(0, 3'b010, 32'h2000, 0, 5'd12, 3, 2, 32'h13579BDF, 0);
    step();
    chk("lw_slow_lat", 32'(seen_done_cyc - acc_cyc), 8);
    chk("lw_slow_data", seen_data, 32'h13579BDF);

    // Grant timeout followed immediately by another request
    do_op(0, 3'b010, 32'h3000, 0, 5'd1, 99, 0, 0, 0);
    do_op(1, 3'b000, 32'h3001, 32'h55, 5'd0, 0, 0, 0, 0);
    step();
    chk("gto_b2b_lat", 32'(seen_done_cyc - acc_cyc), 2);

    // Reset in the middle of a transaction
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    chk("mid_req", dmem_req, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall, 0);
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = bad_codes[$urandom_range(0, 2)];
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_codes[$urandom_range(0, 4)];
      size = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? (1 << f3[1:0]) : 1;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size - 1);
      do_op(st, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom, ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();
    chk("exp_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
